regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the register file's single write port between the in-order writeback stage and the multi-cycle mul/div unit, and keeps a per-register scoreboard of outstanding mul/div results. It sits between the writeback stage and the register file, and also feeds a hazard stall back to decode. The writeback stage has priority. A saturating wait counter stalls the pipeline for one cycle whenever a mul/div result has waited too long.

## Interface
- MAX_WAIT, 4: cycles a valid mul/div result may wait before it forces a grant; legal range 1..15.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- wb_rd  in  5  writeback-stage destination; 0 = no write.
- wb_data  in  32  writeback-stage result.
- wb_ready  out  1  0 = writeback denied this cycle; the core freezes the writeback stage and re-presents the same wb_rd/wb_data.
- md_valid  in  1  mul/div result available.
- md_rd  in  5  mul/div destination.
- md_data  in  32  mul/div result.
- md_ready  out  1  mul/div result accepted when md_valid && md_ready.
- md_issue  in  1  mul/div instruction dispatched this cycle.
- md_issue_rd  in  5  destination of the dispatched mul/div.
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices of the instruction in decode.
- dec_hazard  out  1  decode must stall: one of its indices is busy.
- rf_busy  out  32  scoreboard vector; bit 0 is always 0.
- rf_wr  out  5  register file write address; 0 = no write.
- rf_wr_data  out  32  register file write data.

## Operation
- FSM states and transitions:
  - IDLE: md_valid = 0.
  - WAIT: md_valid = 1 and md_rd ≠ 0, while being denied.
  - FORCE: the grant cycle after the wait counter reaches MAX_WAIT.
- Grant in IDLE/WAIT:
  - wb_rd ≠ 0: writeback gets the port, wb_ready = 1, md_ready = 0.
  - Otherwise: mul/div gets the port if md_valid, md_ready = 1.
- Grant in FORCE: mul/div gets the port, md_ready = 1, wb_ready = 0 (only when wb_rd ≠ 0; wb_ready is 1 otherwise).
- Port mux: rf_wr/rf_wr_data come from the granted source. If neither source is granted, rf_wr = 0 and rf_wr_data = 0.
- x0 results: md_valid with md_rd = 0 is accepted immediately (md_ready = 1) in any state, writes nothing and does not touch the wait counter.
- Wait counter (4 bits):
  - Increments each cycle mul/div is valid and denied; saturates at MAX_WAIT.
  - Clears on any mul/div handshake.
  - FSM: WAIT→FORCE when the counter equals MAX_WAIT. FORCE→IDLE after the handshake, or FORCE→WAIT if a new result is valid next cycle.
  - md_valid dropping without a handshake is a protocol violation. The FSM returns to IDLE and the counter clears.
- Scoreboard:
  - Set: busy[md_issue_rd] on md_issue with md_issue_rd ≠ 0.
  - Clear: busy[md_rd] on a mul/div handshake.
  - Set and clear of the same register in one cycle: set wins.
- dec_hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]. It is combinational from the current busy vector, so a same-cycle clear does not remove the hazard until the next cycle.
- Ordering: the writeback stage never writes a busy register, because decode stalled it (WAW). The arbiter therefore needs no ordering logic between the two sources.

## Timing
- Grant, wb_ready, md_ready, rf_wr, rf_wr_data and dec_hazard are combinational. The FSM, counter and scoreboard are registered.
- Zero-cycle latency from the granted input to rf_wr.
- A mul/div result waits at most MAX_WAIT denied cycles; its grant is in cycle MAX_WAIT+1 after md_valid rises.
- Reset values: FSM = IDLE, counter = 0, rf_busy = 0. Outputs during reset: rf_wr = 0, rf_wr_data = 0, md_ready = 0, wb_ready = 1, dec_hazard = 0.
- Reset mid-operation discards the scoreboard and wait state. The mul/div unit is reset by the same rst.

## Structure
- Shared package riscv_pkg:
  - XLEN = 32, REG_ADDR_W = 5.
  - The FSM state enum arb_state_t {IDLE, WAIT, FORCE}.
- One sub-module, reg_scoreboard: holds the 32-bit busy vector, applies set/clear with set priority and bit 0 forced to 0, and produces the hazard lookup.

## Test plan
- Writeback only: wb_rd=5, wb_data=0x1234, md_valid=0 → rf_wr=5, rf_wr_data=0x1234, wb_ready=1.
- Both valid, no starvation: wb_rd=3 for 2 cycles, md_valid with md_rd=7 → first 2 cycles write r3 with md_ready=0; cycle 3 has wb_rd=0 and writes r7 with md_ready=1.
- Starvation, MAX_WAIT=4: wb_rd≠0 every cycle, md_rd=9 valid from cycle 0 → cycles 0–3 writeback granted; cycle 4 rf_wr=9, md_ready=1, wb_ready=0; cycle 5 the held writeback is granted.
- Scoreboard: md_issue with md_issue_rd=12, then dec_rs2=12 → dec_hazard=1 until the cycle after the md_rd=12 handshake. A same-cycle reissue of r12 keeps busy[12]=1.
- x0 handling: md_issue_rd=0 leaves rf_busy=0. md_valid with md_rd=0 while wb_rd=4 → md_ready=1, rf_wr=4, counter stays 0.
- Reset mid-operation: counter=3 and busy[12]=1, assert rst → next cycle counter=0, rf_busy=0, FSM=IDLE, rf_wr=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions for the register-file write arbiter.
//   XLEN       : data path width
//   REG_ADDR_W : register index width
//   NUM_REGS   : architectural register count (x0..x31)
//   arb_state_t: write-port arbiter FSM state
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // IDLE : no mul/div result pending
  // WAIT : a mul/div result to a real register is being denied
  // FORCE: the denied result has waited its limit and takes the port now
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector for outstanding mul/div results.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   set_en / set_idx  : mark a register busy (mul/div dispatched)
//   clr_en / clr_idx  : mark a register free (mul/div result written)
//   rs1, rs2, rd      : decode-stage indices to look up
//   busy              : registered busy vector, bit 0 always 0
//   hazard            : any looked-up index is busy (from the current vector)
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        // x0 is never written, so it can never be outstanding.
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit    = set_en && (set_idx == REG_ADDR_W'(gi));
        assign clr_hit    = clr_en && (clr_idx == REG_ADDR_W'(gi));
        // A re-dispatch to the register retiring this cycle keeps it busy.
        assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[rs1] | busy_q[rs2] | busy_q[rd];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the writeback stage
// (priority) and the multi-cycle mul/div unit, with anti-starvation and a
// scoreboard of outstanding mul/div destinations.
//   MAX_WAIT          : denied cycles a mul/div result may wait (1..15)
//   clk, rst          : clock, synchronous active-high reset
//   wb_rd/wb_data     : writeback request (wb_rd = 0 means no write)
//   wb_ready          : 0 = writeback held off this cycle
//   md_valid/md_rd/md_data, md_ready : mul/div result handshake
//   md_issue/md_issue_rd : mul/div dispatch, marks destination busy
//   dec_rs1/rs2/rd, dec_hazard       : decode hazard lookup
//   rf_busy           : scoreboard vector
//   rf_wr/rf_wr_data  : register file write port (rf_wr = 0 means no write)
module regfile_write_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_ready,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_data,
  output logic                  md_ready,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_issue_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  dec_hazard,
  output logic [NUM_REGS-1:0]   rf_busy,
  output logic [REG_ADDR_W-1:0] rf_wr,
  output logic [XLEN-1:0]       rf_wr_data
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  arb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       md_real, md_zero, wb_req;
  logic       force_grant, md_grant, wb_grant;
  logic       sb_hazard;

  // Grant and port mux. All outputs are forced to their idle values while
  // rst is high so nothing reaches the register file during reset.
  always_comb begin
    md_zero     = md_valid && (md_rd == '0);
    md_real     = md_valid && (md_rd != '0);
    wb_req      = (wb_rd != '0);
    force_grant = (state_q == FORCE) && md_real;
    md_grant    = !rst && md_real && (force_grant || !wb_req);
    wb_grant    = !rst && wb_req && !force_grant;
    // x0 results are swallowed immediately without using the port.
    md_ready    = md_grant || (!rst && md_zero);
    wb_ready    = rst || !(force_grant && wb_req);

    rf_wr      = '0;
    rf_wr_data = '0;
    if (md_grant) begin
      rf_wr      = md_rd;
      rf_wr_data = md_data;
    end else if (wb_grant) begin
      rf_wr      = wb_rd;
      rf_wr_data = wb_data;
    end
  end

  assign cnt_inc = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 4'd1;

  // Next state. Any cycle that is not a denial (handshake, no result, x0
  // result, or a result that vanished) returns to IDLE with a clear counter.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    unique case (state_q)
      IDLE, WAIT: begin
        if (md_real && !md_grant) begin
          cnt_d   = cnt_inc;
          // Entering FORCE as the counter reaches the limit makes the grant
          // land in cycle MAX_WAIT+1 of the wait.
          state_d = (cnt_inc == MAX_CNT) ? FORCE : WAIT;
        end
      end
      FORCE: begin
        // The pending result is granted here unconditionally.
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (md_issue && (md_issue_rd != '0)),
    .set_idx (md_issue_rd),
    .clr_en  (md_valid && md_ready),
    .clr_idx (md_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .busy    (rf_busy),
    .hazard  (sb_hazard)
  );

  assign dec_hazard = !rst && sb_hazard;

endmodule
